edge_event_arbiter: RTL and testbench

//  Multi-channel edge-event scheduler for mainboard discriminator/trigger lines.

---
 rtl/edge_event_arbiter_pkg.sv | 25 ++
 rtl/edge_event_arbiter_if.sv | 32 +++
 rtl/edge_event_arbiter_edge_capture_ch.sv | 73 +++++++
 rtl/edge_event_arbiter.sv | 136 +++++++++++++
 tb/tb_edge_event_arbiter.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/edge_event_arbiter_pkg.sv
// Shared definitions for the edge-event arbiter: default geometry, per-channel
// edge-mode encodings and helpers that decode a mode into rise/fall enables.
package edge_event_arbiter_pkg;

  localparam int N_CH_DEF = 8;
  localparam int TS_W_DEF = 48;
  localparam int CH_W_DEF = $clog2(N_CH_DEF);
  localparam int OVF_W    = 16;

  typedef enum logic [1:0] {
    EDGE_OFF  = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_e;

  function automatic logic mode_has_rise(logic [1:0] mode);
    return (mode == EDGE_RISE) || (mode == EDGE_BOTH);
  endfunction

  function automatic logic mode_has_fall(logic [1:0] mode);
    return (mode == EDGE_FALL) || (mode == EDGE_BOTH);
  endfunction

endpackage

// File: rtl/edge_event_arbiter_if.sv
// Event output stream towards the readout FIFO: valid/ready plus the event record
// (channel, polarity, timestamp). The arbiter drives it through the master modport.
interface edge_event_arbiter_if
  import edge_event_arbiter_pkg::*;
#(
  parameter int CH_W = CH_W_DEF,
  parameter int TS_W = TS_W_DEF
);

  logic            evt_valid;
  logic            evt_ready;
  logic [CH_W-1:0] evt_ch;
  logic            evt_pol;
  logic [TS_W-1:0] evt_ts;

  modport master (
    output evt_valid,
    output evt_ch,
    output evt_pol,
    output evt_ts,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_ch,
    input  evt_pol,
    input  evt_ts,
    output evt_ready
  );

endinterface

// File: rtl/edge_event_arbiter_edge_capture_ch.sv
// One channel of edge capture: previous-level register, mode-qualified rise/fall
// detection and a one-deep {pol, ts} slot that drops edges arriving while full.
module edge_capture_ch
  import edge_event_arbiter_pkg::*;
#(
  parameter int TS_W = TS_W_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [TS_W-1:0] ts,
  input  logic            det_en,
  input  logic [1:0]      mode,
  input  logic            ch_in,
  input  logic            grant,
  output logic            pend,
  output logic            slot_pol,
  output logic [TS_W-1:0] slot_ts,
  output logic            drop
);

  logic            prev_q, prev_d;
  logic            pend_q, pend_d;
  logic            pol_q, pol_d;
  logic [TS_W-1:0] ts_q, ts_d;
  logic            rise, fall;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves one
    // unassigned and the tool never has to infer a latch to hold an old value.
    prev_d = ch_in;
    pend_d = pend_q;
    pol_d  = pol_q;
    ts_d   = ts_q;
    drop   = 1'b0;

    rise = det_en & mode_has_rise(mode) &  ch_in & ~prev_q;
    fall = det_en & mode_has_fall(mode) & ~ch_in &  prev_q;

    if (grant) pend_d = 1'b0;

    // A slot being emptied by the arbiter this cycle can take the new edge at once.
    if (rise | fall) begin
      if (!pend_q || grant) begin
        pend_d = 1'b1;
        pol_d  = rise;
        ts_d   = ts;
      end else begin
        drop = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop updates from pre-edge values,
    // independent of statement order and of other always_ff blocks.
    if (!rst_n) begin
      prev_q <= 1'b0;
      pend_q <= 1'b0;
      pol_q  <= 1'b0;
      ts_q   <= '0;
    end else begin
      prev_q <= prev_d;
      pend_q <= pend_d;
      pol_q  <= pol_d;
      ts_q   <= ts_d;
    end
  end

  assign pend     = pend_q;
  assign slot_pol = pol_q;
  assign slot_ts  = ts_q;

endmodule

// File: rtl/edge_event_arbiter.sv
// Multi-channel edge-event scheduler: per-channel capture slots share one event
// output register through a round-robin search; dropped edges are counted.
module edge_event_arbiter
  import edge_event_arbiter_pkg::*;
#(
  parameter int N_CH = N_CH_DEF,
  parameter int TS_W = TS_W_DEF,
  parameter int CH_W = $clog2(N_CH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [TS_W-1:0]      ts,
  input  logic                 en,
  input  logic [2*N_CH-1:0]    edge_sel,
  input  logic [N_CH-1:0]      ch_in,
  edge_event_arbiter_if.master evt,
  output logic [OVF_W-1:0]     ovf_cnt,
  input  logic                 ovf_clr
);

  localparam int DC_W = $clog2(N_CH + 1);
  localparam int CW1  = CH_W + 1;

  logic                primed_q, primed_d;
  logic                det_en;
  logic [N_CH-1:0]     pend, grant, drop, slot_pol;
  logic [TS_W-1:0]     slot_ts [N_CH];

  logic                found;
  logic [CH_W-1:0]     win;
  logic [CW1-1:0]      cand;
  logic                out_load;

  logic                valid_q, valid_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic                pol_q, pol_d;
  logic [TS_W-1:0]     out_ts_q, out_ts_d;
  logic [CH_W-1:0]     last_q, last_d;

  logic [DC_W-1:0]     drop_cnt;
  logic [OVF_W:0]      ovf_sum;
  logic [OVF_W-1:0]    ovf_q, ovf_d;

  // primed stays low for the first cycle after release so a line that is already
  // high when reset lifts is absorbed into prev without producing an event.
  assign primed_d = 1'b1;
  assign det_en   = en & primed_q;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    edge_capture_ch #(.TS_W(TS_W)) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .ts      (ts),
      .det_en  (det_en),
      .mode    (edge_sel[2*i +: 2]),
      .ch_in   (ch_in[i]),
      .grant   (grant[i]),
      .pend    (pend[i]),
      .slot_pol(slot_pol[i]),
      .slot_ts (slot_ts[i]),
      .drop    (drop[i])
    );
  end

  // Round-robin: first pending slot at or after last_grant+1, wrapping at N_CH.
  always_comb begin
    found = 1'b0;
    win   = last_q;
    cand  = '0;
    for (int i = 1; i <= N_CH; i++) begin
      cand = {1'b0, last_q} + CW1'(i);
      if (cand >= CW1'(N_CH)) cand = cand - CW1'(N_CH);
      if (!found && pend[cand[CH_W-1:0]]) begin
        found = 1'b1;
        win   = cand[CH_W-1:0];
      end
    end
  end

  always_comb begin
    out_load = ~valid_q | evt.evt_ready;
    grant    = '0;
    valid_d  = valid_q;
    ch_d     = ch_q;
    pol_d    = pol_q;
    out_ts_d = out_ts_q;
    last_d   = last_q;
    if (out_load) begin
      valid_d = found;
      if (found) begin
        grant[win] = 1'b1;
        ch_d       = win;
        pol_d      = slot_pol[win];
        out_ts_d   = slot_ts[win];
        last_d     = win;
      end
    end
  end

  // Clear takes priority but still counts drops from the same cycle.
  always_comb begin
    drop_cnt = '0;
    for (int i = 0; i < N_CH; i++) drop_cnt = drop_cnt + DC_W'(drop[i]);
    ovf_sum = {1'b0, ovf_q} + (OVF_W + 1)'(drop_cnt);
    if (ovf_clr)           ovf_d = OVF_W'(drop_cnt);
    else if (ovf_sum[OVF_W]) ovf_d = '1;
    else                   ovf_d = ovf_sum[OVF_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      primed_q <= 1'b0;
      valid_q  <= 1'b0;
      ch_q     <= '0;
      pol_q    <= 1'b0;
      out_ts_q <= '0;
      last_q   <= CH_W'(N_CH - 1);
      ovf_q    <= '0;
    end else begin
      primed_q <= primed_d;
      valid_q  <= valid_d;
      ch_q     <= ch_d;
      pol_q    <= pol_d;
      out_ts_q <= out_ts_d;
      last_q   <= last_d;
      ovf_q    <= ovf_d;
    end
  end

  assign evt.evt_valid = valid_q;
  assign evt.evt_ch    = ch_q;
  assign evt.evt_pol   = pol_q;
  assign evt.evt_ts    = out_ts_q;
  assign ovf_cnt       = ovf_q;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed bench for edge_event_arbiter: stimulus pushes expected events into a
// scoreboard queue, a negedge monitor pops and compares on each accepted event.
module tb_edge_event_arbiter;
  import edge_event_arbiter_pkg::*;

  localparam int N_CH = 8;
  localparam int TS_W = 48;
  localparam int CH_W = 3;

  typedef struct packed {
    logic [CH_W-1:0] ch;
    logic            pol;
    logic [TS_W-1:0] ts;
  } evt_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [TS_W-1:0] ts;
  logic            en;
  logic [15:0]     edge_sel;
  logic [7:0]      ch_in;
  logic [15:0]     ovf_cnt;
  logic            ovf_clr;

  edge_event_arbiter_if #(.CH_W(CH_W), .TS_W(TS_W)) evt_if ();

  edge_event_arbiter #(.N_CH(N_CH), .TS_W(TS_W), .CH_W(CH_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ts      (ts),
    .en      (en),
    .edge_sel(edge_sel),
    .ch_in   (ch_in),
    .evt     (evt_if),
    .ovf_cnt (ovf_cnt),
    .ovf_clr (ovf_clr)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  evt_t sb_q[$];
  evt_t exp_e;
  evt_t snap;
  logic stalled = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic push(input int ch, input logic pol, input logic [TS_W-1:0] t);
    sb_q.push_back('{ch: CH_W'(ch), pol: pol, ts: t});
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) next_cycle();
  endtask

  // Monitor: payload must hold while stalled; every accepted event is scored.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && evt_if.evt_valid === 1'b1) begin
        if (stalled) begin
          check("hold_ch",  64'(evt_if.evt_ch),  64'(snap.ch));
          check("hold_pol", 64'(evt_if.evt_pol), 64'(snap.pol));
          check("hold_ts",  64'(evt_if.evt_ts),  64'(snap.ts));
        end
        if (evt_if.evt_ready === 1'b1) begin
          stalled = 1'b0;
          check("sb_has_entry", 64'(sb_q.size() != 0), 64'd1);
          if (sb_q.size() != 0) begin
            exp_e = sb_q.pop_front();
            check("evt_ch",  64'(evt_if.evt_ch),  64'(exp_e.ch));
            check("evt_pol", 64'(evt_if.evt_pol), 64'(exp_e.pol));
            check("evt_ts",  64'(evt_if.evt_ts),  64'(exp_e.ts));
          end
        end else begin
          stalled = 1'b1;
          snap    = '{ch: evt_if.evt_ch, pol: evt_if.evt_pol, ts: evt_if.evt_ts};
        end
      end else begin
        stalled = 1'b0;
      end
    end
  end

  initial begin
    // Reset with every line high and every mode on: nothing may come out.
    rst_n = 1'b0; ts = '0; en = 1'b1; edge_sel = 16'hFFFF; ch_in = 8'hFF;
    ovf_clr = 1'b0; evt_if.evt_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 64'(evt_if.evt_valid), 64'd0);
    check("rst_ch",    64'(evt_if.evt_ch),    64'd0);
    check("rst_pol",   64'(evt_if.evt_pol),   64'd0);
    check("rst_ts",    64'(evt_if.evt_ts),    64'd0);
    check("rst_ovf",   64'(ovf_cnt),          64'd0);
    next_cycle();
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("t2_no_evt_on_release", 64'(evt_if.evt_valid), 64'd0);
    end

    // ch3 falls after priming.
    next_cycle();
    ts = 48'd50; ch_in = 8'hF7; push(3, 1'b0, 48'd50);
    wait_cycles(4);
    check("t2_drained", 64'(sb_q.size()), 64'd0);
    edge_sel = 16'h0000; ch_in = 8'h00;
    wait_cycles(2);

    // Single rising edge on ch0: valid exactly one cycle after the detect edge.
    edge_sel = 16'h0001;
    next_cycle();
    ts = 48'd100; ch_in = 8'h01; push(0, 1'b1, 48'd100);
    @(posedge clk);
    @(negedge clk);
    check("t1_valid_detect_cycle", 64'(evt_if.evt_valid), 64'd0);
    @(posedge clk);
    @(negedge clk);
    check("t1_valid_next_cycle", 64'(evt_if.evt_valid), 64'd1);
    @(posedge clk);
    @(negedge clk);
    check("t1_valid_after_accept", 64'(evt_if.evt_valid), 64'd0);
    next_cycle();
    ch_in = 8'h00;
    wait_cycles(3);
    check("t1_fall_ignored", 64'(sb_q.size()), 64'd0);

    // Three simultaneous rises: back-to-back in round-robin order.
    edge_sel = 16'h1104;
    next_cycle();
    ts = 48'd200; ch_in = 8'h52;
    push(1, 1'b1, 48'd200); push(4, 1'b1, 48'd200); push(6, 1'b1, 48'd200);
    @(posedge clk);
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check("t3_back_to_back", 64'(evt_if.evt_valid), 64'd1);
    end
    @(posedge clk);
    @(negedge clk);
    check("t3_idle_after_burst", 64'(evt_if.evt_valid), 64'd0);
    next_cycle();
    ch_in = 8'h00;
    next_cycle();
    edge_sel = 16'h4005;
    next_cycle();
    // Search resumes after ch6: expect 7, then 0, then 1.
    ts = 48'd300; ch_in = 8'h83;
    push(7, 1'b1, 48'd300); push(0, 1'b1, 48'd300); push(1, 1'b1, 48'd300);
    wait_cycles(5);
    check("t3_drained", 64'(sb_q.size()), 64'd0);
    ch_in = 8'h00;
    next_cycle();
    edge_sel = 16'h0000;
    next_cycle();

    // Backpressure: three toggles on ch2 -> presented, slotted, dropped.
    evt_if.evt_ready = 1'b0;
    edge_sel = 16'h0030;
    next_cycle();
    ts = 48'd400; ch_in = 8'h04; push(2, 1'b1, 48'd400);
    next_cycle();
    ts = 48'd401; ch_in = 8'h00; push(2, 1'b0, 48'd401);
    next_cycle();
    ts = 48'd402; ch_in = 8'h04;
    next_cycle();
    @(negedge clk);
    check("t4_ovf_one",  64'(ovf_cnt),          64'd1);
    check("t4_valid",    64'(evt_if.evt_valid), 64'd1);
    check("t4_first_ts", 64'(evt_if.evt_ts),    64'd400);
    wait_cycles(3);
    evt_if.evt_ready = 1'b1;
    wait_cycles(4);
    check("t4_drained", 64'(sb_q.size()), 64'd0);
    check("t4_ovf_kept", 64'(ovf_cnt), 64'd1);
    edge_sel = 16'h0000; ch_in = 8'h00;
    wait_cycles(2);

    // Saturation: all channels toggle every cycle with the output stalled.
    evt_if.evt_ready = 1'b0;
    edge_sel = 16'hFFFF;
    for (int i = 0; i < 8500; i++) begin
      next_cycle();
      ch_in = ~ch_in;
    end
    @(negedge clk);
    check("t5_ovf_saturated", 64'(ovf_cnt), 64'hFFFF);
    next_cycle();
    ch_in = ~ch_in;
    @(negedge clk);
    check("t5_ovf_sat_hold", 64'(ovf_cnt), 64'hFFFF);
    next_cycle();
    edge_sel = 16'h000F; ch_in = ~ch_in; ovf_clr = 1'b1;
    @(negedge clk);
    check("t5_pre_clear", 64'(ovf_cnt), 64'hFFFF);
    next_cycle();
    ovf_clr = 1'b0;
    @(negedge clk);
    check("t5_clr_with_drops", 64'(ovf_cnt), 64'd2);
    next_cycle();
    @(negedge clk);
    check("t5_clr_stable", 64'(ovf_cnt), 64'd2);

    // Reset while presenting with full slots: everything discarded.
    next_cycle();
    rst_n = 1'b0; edge_sel = 16'hFFFF; ch_in = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    check("t6_rst_valid", 64'(evt_if.evt_valid), 64'd0);
    check("t6_rst_ovf",   64'(ovf_cnt),          64'd0);
    next_cycle();
    evt_if.evt_ready = 1'b1;
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("t6_no_evt_after_release", 64'(evt_if.evt_valid), 64'd0);
    end
    check("final_sb_empty", 64'(sb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
